fp_unit_arbiter: RTL

//   Shares one fpoint_wrapper-style FP custom-instruction unit (start/done/n handshake) between
//   NUM_REQ Avalon-side requesters (e.g. several dma_access-type register blocks).

---
 rtl/fp_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/fp_unit_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// Shared state encoding, FP custom-instruction opcodes and width helper for the FP unit arbiter.
package fp_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_ABORT = 3'd4
   } arb_state_t;

   localparam logic [7:0] FP_OP_MUL = 8'd252;
   localparam logic [7:0] FP_OP_ADD = 8'd253;
   localparam logic [7:0] FP_OP_SUB = 8'd254;
   localparam logic [7:0] FP_OP_DIV = 8'd255;

   // Bits needed to hold 0..value-1, never less than one.
   function automatic int clog2(input int value);
      int w;
      w = 1;
      while ((1 << w) < value) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter
   import fp_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int               slot;
      logic [IDX_W-1:0] s;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      slot  = 0;
      s     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         slot = int'(ptr) + k;
         if (slot >= NUM_REQ) slot = slot - NUM_REQ;
         s = IDX_W'(slot);
         if (!any && req[s]) begin
            any      = 1'b1;
            grant[s] = 1'b1;
            idx      = s;
         end
      end
   end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin sharing of one start/done FP custom-instruction unit between NUM_REQ requesters,
// with a saturating watchdog that aborts and resets a hung unit.
module fp_unit_arbiter
   import fp_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 32,
   parameter int OP_W        = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_dataa,
   input  logic [NUM_REQ*DATA_W-1:0] req_datab,
   input  logic [NUM_REQ*OP_W-1:0]   req_n,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_error,
   output logic                      fpu_clk_en,
   output logic                      fpu_start,
   output logic                      fpu_reset,
   output logic [DATA_W-1:0]         fpu_dataa,
   output logic [DATA_W-1:0]         fpu_datab,
   output logic [OP_W-1:0]           fpu_n,
   input  logic                      fpu_done,
   input  logic [DATA_W-1:0]         fpu_result,
   output logic [2:0]                dbg_state,
   output logic [clog2(NUM_REQ)-1:0] dbg_rr_ptr
);

   localparam int IDX_W = clog2(NUM_REQ);
   localparam int WD_W  = clog2(TIMEOUT_CYC + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   arb_state_t         state, state_nx;
   logic [IDX_W-1:0]   rr_ptr, gnt_idx, arb_idx;
   logic [NUM_REQ-1:0] arb_grant;
   logic               arb_any;
   logic [DATA_W-1:0]  a_q, b_q, res_q, sel_a, sel_b;
   logic [OP_W-1:0]    n_q, sel_n;
   logic [WD_W-1:0]    wd_cnt;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      sel_n = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_a = sel_a | (req_dataa[i*DATA_W +: DATA_W] & {DATA_W{arb_grant[i]}});
         sel_b = sel_b | (req_datab[i*DATA_W +: DATA_W] & {DATA_W{arb_grant[i]}});
         sel_n = sel_n | (req_n[i*OP_W +: OP_W] & {OP_W{arb_grant[i]}});
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         rr_ptr  <= '0;
         gnt_idx <= '0;
         a_q     <= '0;
         b_q     <= '0;
         n_q     <= '0;
         res_q   <= '0;
         wd_cnt  <= '0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: if (arb_any) begin
               gnt_idx <= arb_idx;
               a_q     <= sel_a;
               b_q     <= sel_b;
               n_q     <= sel_n;
            end
            ST_ISSUE: begin
               wd_cnt <= '0;
               if (fpu_done) res_q <= fpu_result;
            end
            ST_WAIT: begin
               if (fpu_done) res_q <= fpu_result;
               else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
            end
            ST_RESP, ST_ABORT: rr_ptr <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
            default: ;
         endcase
      end
   end

   // Handshake: a requester holds req_valid and operands until its one-cycle req_ready pulse
   // (issued in ISSUE, when operands are already latched) and drops valid the next cycle; the
   // owner then receives exactly one rsp_valid pulse, with rsp_error marking a watchdog abort.
   always_comb begin
      state_nx   = state;
      req_ready  = '0;
      rsp_valid  = '0;
      rsp_result = '0;
      rsp_error  = 1'b0;
      fpu_clk_en = 1'b0;
      fpu_start  = 1'b0;
      case (state)
         ST_IDLE: if (arb_any) state_nx = ST_ISSUE;
         ST_ISSUE: begin
            req_ready[gnt_idx] = 1'b1;
            fpu_start          = 1'b1;
            fpu_clk_en         = 1'b1;
            state_nx           = fpu_done ? ST_RESP : ST_WAIT;
         end
         ST_WAIT: begin
            fpu_clk_en = 1'b1;
            if (fpu_done)              state_nx = ST_RESP;
            else if (wd_cnt == WD_LAST) state_nx = ST_ABORT;
         end
         ST_RESP: begin
            rsp_valid[gnt_idx] = 1'b1;
            rsp_result         = res_q;
            state_nx           = ST_IDLE;
         end
         ST_ABORT: begin
            rsp_valid[gnt_idx] = 1'b1;
            rsp_error          = 1'b1;
            state_nx           = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign fpu_reset  = reset | (state == ST_ABORT);
   assign fpu_dataa  = a_q;
   assign fpu_datab  = b_q;
   assign fpu_n      = n_q;
   assign dbg_state  = state;
   assign dbg_rr_ptr = rr_ptr;

endmodule
